// File: rtl/imem_pkg.sv
// Shared defaults and state encodings for the instruction-memory port arbiter.
// The memory is a single port shared by instruction fetch and the program loader.
package imem_pkg;

  localparam int DEPTH_DEF      = 128;
  localparam int AW_DEF         = 7;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_L = 1'b1
  } owner_t;

endpackage

// File: rtl/imem_starve_cnt.sv
// Saturating count of loader grants handed out while fetch is left waiting.
// o_sat tells the arbiter that fetch must win the next contended cycle.
module imem_starve_cnt
  import imem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CW         = $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  logic [CW-1:0] r_cnt;

  // Clear takes precedence: a fetch grant or an absent fetch request ends starvation.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != CW'(STARVE_MAX)))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_sat = (r_cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates fetch and loader onto one instruction-memory port: single-cycle
// grants in IDLE, one-cycle read turnaround in RD_WAIT, out-of-range addresses flagged.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AW         = AW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic          f_err,
  output logic [31:0]   f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic          l_err,
  output logic [31:0]   l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  state_t      r_state;
  owner_t      r_owner;
  logic [31:0] r_f_rdata;
  logic [31:0] r_l_rdata;

  logic w_idle, w_sat;
  logic w_f_oob, w_l_oob;
  logic w_f_win, w_l_win;
  logic w_f_rd, w_l_rd, w_l_wr;
  logic w_f_rv, w_l_rv;

  // Every grant path is qualified by rst_n so outputs drop in the reset cycle itself.
  assign w_idle  = rst_n && (r_state == IDLE);
  assign w_f_oob = (f_addr >= 32'(DEPTH));
  assign w_l_oob = (l_addr >= 32'(DEPTH));

  assign w_f_win = w_idle && f_req && (!l_req || w_sat);
  assign w_l_win = w_idle && l_req && !w_f_win;

  assign w_f_rd  = w_f_win && !w_f_oob;
  assign w_l_rd  = w_l_win && !w_l_oob && !l_we;
  assign w_l_wr  = w_l_win && !w_l_oob &&  l_we;

  assign w_f_rv  = rst_n && (r_state == RD_WAIT) && (r_owner == OWN_F);
  assign w_l_rv  = rst_n && (r_state == RD_WAIT) && (r_owner == OWN_L);

  imem_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_l_win && f_req),
    .i_clr (w_f_win || !f_req),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= OWN_F;
      r_f_rdata <= '0;
      r_l_rdata <= '0;
    end else begin
      if (w_f_rv) r_f_rdata <= mem_rdata;
      if (w_l_rv) r_l_rdata <= mem_rdata;
      case (r_state)
        IDLE: begin
          if (w_f_rd) begin
            r_state <= RD_WAIT;
            r_owner <= OWN_F;
          end else if (w_l_rd) begin
            r_state <= RD_WAIT;
            r_owner <= OWN_L;
          end
        end
        RD_WAIT: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign f_gnt     = w_f_win;
  assign f_err     = w_f_win && w_f_oob;
  assign l_gnt     = w_l_win;
  assign l_err     = w_l_win && w_l_oob;

  assign mem_en    = w_f_rd || w_l_rd || w_l_wr;
  assign mem_we    = w_l_wr;
  assign mem_addr  = w_l_win ? l_addr[AW-1:0] : (w_f_win ? f_addr[AW-1:0] : '0);
  assign mem_wdata = w_l_wr ? l_wdata : '0;

  // Read data passes straight through on the rvalid cycle and is held afterwards.
  assign f_rvalid  = w_f_rv;
  assign l_rvalid  = w_l_rv;
  assign f_rdata   = !rst_n ? '0 : (w_f_rv ? mem_rdata : r_f_rdata);
  assign l_rdata   = !rst_n ? '0 : (w_l_rv ? mem_rdata : r_l_rdata);
  assign busy      = rst_n && (r_state == RD_WAIT);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: behavioural memory, read-data scoreboard,
// a table of single-cycle grant vectors and hand-written multi-cycle sequences.
module tb_imem_port_arbiter;

  logic        clk, rst_n;
  logic        f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_we, l_gnt, l_rvalid, l_err;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        mem_en, mem_we, busy;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  imem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_err(f_err), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_err(l_err), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural memory: synchronous read, one cycle latency.
  logic [31:0] mem [128];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h1294_0000 | 32'(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Scoreboard: golden image of memory, expected read data queued at grant.
  logic [31:0] golden [128];
  logic [31:0] fq[$];
  logic [31:0] lq[$];
  logic        pf = 1'b0, pl = 1'b0;
  logic [31:0] sb_d;

  initial for (int i = 0; i < 128; i++) golden[i] = 32'h1294_0000 | 32'(i);

  always @(negedge clk) begin
    chk("f_rvalid_timing", {31'd0, f_rvalid}, {31'd0, pf && rst_n});
    chk("l_rvalid_timing", {31'd0, l_rvalid}, {31'd0, pl && rst_n});
    chk("busy_timing",     {31'd0, busy},     {31'd0, (pf || pl) && rst_n});
    if (pf && !rst_n && fq.size() > 0) void'(fq.pop_front());
    if (pl && !rst_n && lq.size() > 0) void'(lq.pop_front());
    if (f_rvalid) begin
      if (fq.size() == 0) begin
        total++; bad++;
        $display("FAIL f_sb: unexpected f_rvalid data %h", f_rdata);
      end else begin
        sb_d = fq.pop_front();
        chk("f_sb_data", f_rdata, sb_d);
      end
    end
    if (l_rvalid) begin
      if (lq.size() == 0) begin
        total++; bad++;
        $display("FAIL l_sb: unexpected l_rvalid data %h", l_rdata);
      end else begin
        sb_d = lq.pop_front();
        chk("l_sb_data", l_rdata, sb_d);
      end
    end
    if (rst_n && l_gnt && !l_err &&  l_we) golden[l_addr[6:0]] = l_wdata;
    if (rst_n && f_gnt && !f_err)          fq.push_back(golden[f_addr[6:0]]);
    if (rst_n && l_gnt && !l_err && !l_we) lq.push_back(golden[l_addr[6:0]]);
    pf = rst_n && f_gnt && !f_err;
    pl = rst_n && l_gnt && !l_err && !l_we;
  end

  typedef struct {
    string       name;
    logic        f_req;
    logic [31:0] f_addr;
    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        fg, lg, fe, le, men, mwe;
    logic [6:0]  maddr;
  } vec_t;

  vec_t vt [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
  endtask

  function automatic logic [31:0] wv(input int i);
    return 32'hA5A5_0000 + 32'(i) * 32'h0101;
  endfunction

  task automatic fetch_rd(input logic [31:0] a, input logic [31:0] e);
    step(); f_req = 1; f_addr = a;
    @(negedge clk);
    chk("rd_gnt", {31'd0, f_gnt}, 32'd1);
    chk("rd_busy0", {31'd0, busy}, 32'd0);
    step(); f_req = 0;
    @(negedge clk);
    chk("rd_rvalid", {31'd0, f_rvalid}, 32'd1);
    chk("rd_busy1", {31'd0, busy}, 32'd1);
    chk("rd_data", f_rdata, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    //            name          fr f_addr  lr we l_addr  l_wdata        fg lg fe le men mwe maddr
    vt[0] = '{"f_rd3",         1, 32'd3,   0, 0, 32'd0,   32'd0,         1, 0, 0, 0, 1, 0, 7'd3};
    vt[1] = '{"l_wr10",        0, 32'd0,   1, 1, 32'd10,  32'hDEAD_BEEF, 0, 1, 0, 0, 1, 1, 7'd10};
    vt[2] = '{"l_rd10",        0, 32'd0,   1, 0, 32'd10,  32'd0,         0, 1, 0, 0, 1, 0, 7'd10};
    vt[3] = '{"both_rd",       1, 32'd6,   1, 0, 32'd7,   32'd0,         0, 1, 0, 0, 1, 0, 7'd7};
    vt[4] = '{"f_oob128",      1, 32'd128, 0, 0, 32'd0,   32'd0,         1, 0, 1, 0, 0, 0, 7'd0};
    vt[5] = '{"l_wr_oob200",   0, 32'd0,   1, 1, 32'd200, 32'h1111_2222, 0, 1, 0, 1, 0, 0, 7'd0};
    vt[6] = '{"both_oob",      1, 32'd300, 1, 0, 32'd129, 32'd0,         0, 1, 0, 1, 0, 0, 7'd0};
    vt[7] = '{"f_rd127",       1, 32'd127, 0, 0, 32'd0,   32'd0,         1, 0, 0, 0, 1, 0, 7'd127};
    vt[8] = '{"l_oob_over_f",  1, 32'd5,   1, 0, 32'd130, 32'd0,         0, 1, 0, 1, 0, 0, 7'd0};
    vt[9] = '{"no_req",        0, 32'd0,   0, 0, 32'd0,   32'd0,         0, 0, 0, 0, 0, 0, 7'd0};

    // Reset with requests asserted: outputs must be gated low.
    rst_n = 0; idle_in(); f_req = 1; f_addr = 3; l_req = 1; l_addr = 4;
    @(negedge clk);
    chk("rst_ctrl", {25'd0, f_gnt, l_gnt, f_err, l_err, mem_en, mem_we, busy}, 32'd0);
    chk("rst_frdata", f_rdata, 32'd0);
    chk("rst_lrdata", l_rdata, 32'd0);
    step(); step();
    mem_ready = 1'b1; rst_n = 1; idle_in();
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Single fetch read of word 3, then hold of rdata.
    fetch_rd(32'd3, 32'h1294_0003);
    step();
    @(negedge clk);
    chk("f_rdata_hold", f_rdata, 32'h1294_0003);
    chk("f_rvalid_once", {31'd0, f_rvalid}, 32'd0);

    // Table of single-cycle grant vectors, each from IDLE with starve=0.
    for (int i = 0; i < 10; i++) begin
      step();
      f_req = vt[i].f_req; f_addr = vt[i].f_addr;
      l_req = vt[i].l_req; l_we = vt[i].l_we; l_addr = vt[i].l_addr; l_wdata = vt[i].l_wdata;
      @(negedge clk);
      chk({vt[i].name, ".gnt_err"}, {28'd0, f_gnt, l_gnt, f_err, l_err},
          {28'd0, vt[i].fg, vt[i].lg, vt[i].fe, vt[i].le});
      chk({vt[i].name, ".mem"}, {30'd0, mem_en, mem_we}, {30'd0, vt[i].men, vt[i].mwe});
      if (vt[i].men) chk({vt[i].name, ".maddr"}, {25'd0, mem_addr}, {25'd0, vt[i].maddr});
      if (vt[i].mwe) chk({vt[i].name, ".mwdata"}, mem_wdata, vt[i].l_wdata);
      step(); idle_in();
      step();
    end

    // Back-to-back loader writes 0..7, then fetch them back.
    for (int i = 0; i < 8; i++) begin
      step();
      l_req = 1; l_we = 1; l_addr = 32'(i); l_wdata = wv(i);
      @(negedge clk);
      chk("bb_lgnt", {30'd0, l_gnt, mem_we}, 32'd3);
    end
    step(); idle_in();
    for (int i = 0; i < 8; i++) fetch_rd(32'(i), wv(i));

    // Contention: loader writes held against a held fetch read.
    step(); idle_in();
    step();
    f_req = 1; f_addr = 4; l_req = 1; l_we = 1; l_addr = 20; l_wdata = 32'h0000_0055;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      chk("cont_lgnt", {31'd0, l_gnt}, {31'd0, (c % 6) < 4});
      chk("cont_fgnt", {31'd0, f_gnt}, {31'd0, (c % 6) == 4});
      step();
    end
    idle_in();
    step();

    // Reset during RD_WAIT abandons the read.
    step(); f_req = 1; f_addr = 2;
    @(negedge clk);
    chk("rmr_gnt", {31'd0, f_gnt}, 32'd1);
    step(); f_req = 0; rst_n = 0;
    @(negedge clk);
    chk("rmr_rvalid", {31'd0, f_rvalid}, 32'd0);
    chk("rmr_busy", {31'd0, busy}, 32'd0);
    step(); rst_n = 1;
    @(negedge clk);
    chk("rmr_after", {30'd0, f_rvalid, busy}, 32'd0);
    chk("rmr_rdata", f_rdata, 32'd0);
    fetch_rd(32'd2, wv(2));

    // Simultaneous reads: loader first, fetch granted two cycles later.
    step(); idle_in();
    step();
    f_req = 1; f_addr = 1; l_req = 1; l_we = 0; l_addr = 2;
    @(negedge clk);
    chk("sim_c0", {30'd0, l_gnt, f_gnt}, 32'd2);
    step(); l_req = 0;
    @(negedge clk);
    chk("sim_c1_lrv", {31'd0, l_rvalid}, 32'd1);
    chk("sim_c1_ldata", l_rdata, wv(2));
    chk("sim_c1_fgnt", {31'd0, f_gnt}, 32'd0);
    step();
    @(negedge clk);
    chk("sim_c2_fgnt", {31'd0, f_gnt}, 32'd1);
    step(); f_req = 0;
    @(negedge clk);
    chk("sim_c3_fdata", f_rdata, wv(1));
    chk("sim_ldata_hold", l_rdata, wv(2));

    step(); idle_in();
    repeat (3) step();
    chk("sb_f_empty", fq.size(), 32'd0);
    chk("sb_l_empty", lq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
